// File: rtl/scroll_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : scroll_addr_gen_if
// Purpose  : Timing-controller <-> scroll address generator signal bundle.
//            Optional mirror input is present when SCROLL_MIRROR_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface scroll_addr_gen_if #(
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 16
);
  logic [CNT_W-1:0]  h_cnt_i;
  logic [CNT_W-1:0]  v_cnt_i;
  logic              frame_tick_i;
  logic              pause_i;
  logic              step_i;
  logic              backward_i;
  logic              vmode_i;
`ifdef SCROLL_MIRROR_EN
  logic              mirror_i;
`endif
  logic [ADDR_W-1:0] pixel_addr_o;
  logic              pixel_valid_o;
  logic [CNT_W-1:0]  pos_h_o;
  logic [CNT_W-1:0]  pos_v_o;
  logic              running_o;

  modport master (
    output h_cnt_i, v_cnt_i, frame_tick_i, pause_i, step_i, backward_i, vmode_i,
`ifdef SCROLL_MIRROR_EN
    output mirror_i,
`endif
    input  pixel_addr_o, pixel_valid_o, pos_h_o, pos_v_o, running_o
  );

  modport slave (
    input  h_cnt_i, v_cnt_i, frame_tick_i, pause_i, step_i, backward_i, vmode_i,
`ifdef SCROLL_MIRROR_EN
    input  mirror_i,
`endif
    output pixel_addr_o, pixel_valid_o, pos_h_o, pos_v_o, running_o
  );
endinterface
`default_nettype wire

// File: rtl/scroll_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : scroll_addr_gen
// Purpose  : Scrolling-image ROM address generator with pause/step/speed
//            control. Define SCROLL_MIRROR_EN to add horizontal mirroring.
// Revision : 1.0  initial release
// ============================================================================
module scroll_addr_gen #(
  parameter int IMG_W       = 260,
  parameter int IMG_H       = 120,
  parameter int H_START     = 160,
  parameter int V_START     = 120,
  parameter int SCALE_SHIFT = 1,
  parameter int SPEED_DIV   = 1,
  parameter int CNT_W       = 10,
  parameter int ADDR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  scroll_addr_gen_if.slave bus
);

  localparam logic [1:0] S_PAUSED = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;

  localparam int               SPD_W      = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [SPD_W-1:0] SPD_LAST   = SPD_W'(SPEED_DIV - 1);
  localparam logic [CNT_W-1:0] POS_H_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] POS_V_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W:0]   IMG_W_X    = (CNT_W+1)'(IMG_W);
  localparam logic [CNT_W:0]   IMG_H_X    = (CNT_W+1)'(IMG_H);
  localparam logic [CNT_W:0]   H_LO       = (CNT_W+1)'(H_START);
  localparam logic [CNT_W:0]   H_HI       = (CNT_W+1)'(H_START + (IMG_W << SCALE_SHIFT));
  localparam logic [CNT_W:0]   V_LO       = (CNT_W+1)'(V_START);
  localparam logic [CNT_W:0]   V_HI       = (CNT_W+1)'(V_START + (IMG_H << SCALE_SHIFT));

  logic [1:0]        state_q, state_d;
  logic              pause_q, step_q;
  logic              pause_edge, step_edge;
  logic [SPD_W-1:0]  spd_q, spd_d;
  logic [CNT_W-1:0]  pos_h_q, pos_h_d;
  logic [CNT_W-1:0]  pos_v_q, pos_v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              running;
  logic              advance;

  logic [CNT_W:0]    h_ext, v_ext, h_rel, v_rel;
  logic [CNT_W:0]    col_sum, row_sum, col, row;

  assign pause_edge = bus.pause_i & ~pause_q;
  assign step_edge  = bus.step_i  & ~step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Pause beats step when both edges land in the same PAUSED cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PAUSED: begin
        if (pause_edge) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (pause_edge) begin
          state_d = S_PAUSED;
        end
      end
      S_STEP:  state_d = S_PAUSED;
      default: state_d = S_PAUSED;
    endcase
  end

  always_comb begin
    running = 1'b0;
    advance = 1'b0;
    spd_d   = spd_q;
    case (state_q)
      S_RUN: begin
        running = 1'b1;
        if (pause_edge) begin
          spd_d = '0;
        end else if (bus.frame_tick_i) begin
          if (spd_q == SPD_LAST) begin
            spd_d   = '0;
            advance = 1'b1;
          end else begin
            spd_d = spd_q + 1'b1;
          end
        end
      end
      S_STEP:  advance = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pos_h_d = pos_h_q;
    pos_v_d = pos_v_q;
    if (advance) begin
      if (!bus.vmode_i) begin
        if (bus.backward_i) begin
          pos_h_d = (pos_h_q == '0) ? POS_H_LAST : pos_h_q - 1'b1;
        end else begin
          pos_h_d = (pos_h_q == POS_H_LAST) ? '0 : pos_h_q + 1'b1;
        end
      end else begin
        if (bus.backward_i) begin
          pos_v_d = (pos_v_q == '0) ? POS_V_LAST : pos_v_q - 1'b1;
        end else begin
          pos_v_d = (pos_v_q == POS_V_LAST) ? '0 : pos_v_q + 1'b1;
        end
      end
    end
  end

  // One extra bit keeps offset + position sums from overflowing before the wrap compare.
  always_comb begin
    h_ext   = {1'b0, bus.h_cnt_i};
    v_ext   = {1'b0, bus.v_cnt_i};
    h_rel   = (h_ext - H_LO) >> SCALE_SHIFT;
    v_rel   = (v_ext - V_LO) >> SCALE_SHIFT;
    col_sum = h_rel + {1'b0, pos_h_q};
    row_sum = v_rel + {1'b0, pos_v_q};
    col     = (col_sum >= IMG_W_X) ? col_sum - IMG_W_X : col_sum;
    row     = (row_sum >= IMG_H_X) ? row_sum - IMG_H_X : row_sum;
`ifdef SCROLL_MIRROR_EN
    if (bus.mirror_i) begin
      col = IMG_W_X - (CNT_W+1)'(1) - col;
    end
`endif
    valid_d = (h_ext >= H_LO) && (h_ext < H_HI) && (v_ext >= V_LO) && (v_ext < V_HI);
    addr_d  = valid_d ? (ADDR_W'(col) + ADDR_W'(IMG_W) * ADDR_W'(row)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
      step_q  <= 1'b0;
      spd_q   <= '0;
      pos_h_q <= '0;
      pos_v_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pause_q <= bus.pause_i;
      step_q  <= bus.step_i;
      spd_q   <= spd_d;
      pos_h_q <= pos_h_d;
      pos_v_q <= pos_v_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pixel_addr_o  = addr_q;
  assign bus.pixel_valid_o = valid_q;
  assign bus.pos_h_o       = pos_h_q;
  assign bus.pos_v_o       = pos_v_q;
  assign bus.running_o     = running;

endmodule
`default_nettype wire

// File: tb/tb_scroll_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_scroll_addr_gen
// Purpose  : Scoreboard bench for scroll_addr_gen (SPEED_DIV 1 and 4 side by
//            side); honours SCROLL_MIRROR_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_scroll_addr_gen;

  localparam int IMG_W       = 260;
  localparam int IMG_H       = 120;
  localparam int H_START     = 160;
  localparam int V_START     = 120;
  localparam int SCALE_SHIFT = 1;
  localparam int CNT_W       = 10;
  localparam int ADDR_W      = 16;

  typedef struct packed {
    int addr;
    int ph;
    int pv;
    int run;
  } dexp_t;

  typedef struct packed {
    int    cyc;
    int    valid;
    dexp_t d1;
    dexp_t d4;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_cnt = 0;
  int   n_chk = 0;
  int   n_err = 0;

  bit pause, step, ft, bwd, vm, mir;
  int h, v;

  int m_ph[2], m_pv[2], m_cnt[2];
  bit m_run[2], m_stepdue[2];
  bit prev_p, prev_s;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  scroll_addr_gen_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) if1 ();
  scroll_addr_gen_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) if4 ();

  scroll_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .H_START(H_START), .V_START(V_START),
                    .SCALE_SHIFT(SCALE_SHIFT), .SPEED_DIV(1), .CNT_W(CNT_W), .ADDR_W(ADDR_W))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  scroll_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .H_START(H_START), .V_START(V_START),
                    .SCALE_SHIFT(SCALE_SHIFT), .SPEED_DIV(4), .CNT_W(CNT_W), .ADDR_W(ADDR_W))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    if1.h_cnt_i = CNT_W'(h);     if4.h_cnt_i = CNT_W'(h);
    if1.v_cnt_i = CNT_W'(v);     if4.v_cnt_i = CNT_W'(v);
    if1.frame_tick_i = ft;       if4.frame_tick_i = ft;
    if1.pause_i = pause;         if4.pause_i = pause;
    if1.step_i = step;           if4.step_i = step;
    if1.backward_i = bwd;        if4.backward_i = bwd;
    if1.vmode_i = vm;            if4.vmode_i = vm;
`ifdef SCROLL_MIRROR_EN
    if1.mirror_i = mir;          if4.mirror_i = mir;
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_pv[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_stepdue[k] = 0;
    end
    prev_p = 0;
    prev_s = 0;
  endtask

  // Image address of the current (h,v) for a given scroll offset.
  function automatic int ref_addr(input int ph, input int pv, output bit vld);
    int col, row;
    vld = (h >= H_START) && (h < H_START + IMG_W * (1 << SCALE_SHIFT)) &&
          (v >= V_START) && (v < V_START + IMG_H * (1 << SCALE_SHIFT));
    if (!vld) return 0;
    col = (((h - H_START) >> SCALE_SHIFT) + ph) % IMG_W;
    row = (((v - V_START) >> SCALE_SHIFT) + pv) % IMG_H;
`ifdef SCROLL_MIRROR_EN
    if (mir) col = IMG_W - 1 - col;
`endif
    return col + IMG_W * row;
  endfunction

  task automatic model_step(input int k, input bit pe, input bit se);
    bit adv = 0;
    int div = (k == 0) ? 1 : 4;
    if (m_stepdue[k]) begin
      adv = 1;
      m_stepdue[k] = 0;
    end else if (m_run[k]) begin
      if (pe) begin
        m_run[k] = 0;
        m_cnt[k] = 0;
      end else if (ft) begin
        m_cnt[k]++;
        if (m_cnt[k] == div) begin
          m_cnt[k] = 0;
          adv = 1;
        end
      end
    end else begin
      if (pe) m_run[k] = 1;
      else if (se) m_stepdue[k] = 1;
    end
    if (adv) begin
      if (vm) m_pv[k] = (m_pv[k] + (bwd ? IMG_H - 1 : 1)) % IMG_H;
      else    m_ph[k] = (m_ph[k] + (bwd ? IMG_W - 1 : 1)) % IMG_W;
    end
  endtask

  // Drive one cycle's inputs, queue the outputs expected after the coming edge.
  task automatic cycle();
    exp_t e;
    bit   pe, se, vld0, vld1;
    int   a0, a1;
    apply();
    e = '0;
    e.cyc = cyc_cnt + 1;
    if (!rst_n) begin
      model_reset();
    end else begin
      pe = pause && !prev_p;
      se = step && !prev_s;
      a0 = ref_addr(m_ph[0], m_pv[0], vld0);
      a1 = ref_addr(m_ph[1], m_pv[1], vld1);
      model_step(0, pe, se);
      model_step(1, pe, se);
      prev_p = pause;
      prev_s = step;
      e.valid = int'(vld0);
      e.d1 = '{addr: a0, ph: m_ph[0], pv: m_pv[0], run: int'(m_run[0])};
      e.d4 = '{addr: a1, ph: m_ph[1], pv: m_pv[1], run: int'(m_run[1])};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("async_rst_addr1",  int'(if1.pixel_addr_o), 0);
    chk("async_rst_valid1", int'(if1.pixel_valid_o), 0);
    chk("async_rst_pos_h1", int'(if1.pos_h_o), 0);
    chk("async_rst_pos_v1", int'(if1.pos_v_o), 0);
    chk("async_rst_run1",   int'(if1.running_o), 0);
    chk("async_rst_pos_h4", int'(if4.pos_h_o), 0);
    chk("async_rst_run4",   int'(if4.running_o), 0);
    model_reset();
    pause = 0; step = 0; ft = 0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
      chk("sb_missed_cycle", cyc_cnt, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      mon_e = sb.pop_front();
      chk("addr1",   int'(if1.pixel_addr_o),  mon_e.d1.addr);
      chk("valid1",  int'(if1.pixel_valid_o), mon_e.valid);
      chk("pos_h1",  int'(if1.pos_h_o),       mon_e.d1.ph);
      chk("pos_v1",  int'(if1.pos_v_o),       mon_e.d1.pv);
      chk("run1",    int'(if1.running_o),     mon_e.d1.run);
      chk("addr4",   int'(if4.pixel_addr_o),  mon_e.d4.addr);
      chk("valid4",  int'(if4.pixel_valid_o), mon_e.valid);
      chk("pos_h4",  int'(if4.pos_h_o),       mon_e.d4.ph);
      chk("pos_v4",  int'(if4.pos_v_o),       mon_e.d4.pv);
      chk("run4",    int'(if4.running_o),     mon_e.d4.run);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pause = 0; step = 0; ft = 0; bwd = 0; vm = 0; mir = 0;
    h = 200; v = 150;
    model_reset();
    apply();
    @(posedge clk);
    #1;
    chk("reset_addr",  int'(if1.pixel_addr_o), 0);
    chk("reset_valid", int'(if1.pixel_valid_o), 0);
    repeat (3) cycle();

    rst_n = 1'b1;
    cycle();
    cycle();

    pause = 1; cycle(); pause = 0; cycle();
    repeat (3) begin ft = 1; cycle(); ft = 0; cycle(); end
    h = 160; v = 120;
    cycle(); cycle();

    ft = 1; repeat (256) cycle();
    cycle();
    bwd = 1; cycle();
    ft = 0; bwd = 0; cycle();

    pause = 1; cycle(); pause = 0; cycle();
    repeat (5) begin ft = 1; cycle(); ft = 0; cycle(); end

    step = 1; cycle(); step = 0; cycle(); cycle();
    pause = 1; step = 1; cycle(); pause = 0; step = 0; cycle(); cycle();
    step = 1; cycle(); step = 0; cycle();

    vm = 1; ft = 1;
    h = 160; v = 120 + 2 * 116;
    repeat (125) cycle();
    ft = 0; vm = 0; cycle();

    for (int i = 0; i < 3000; i++) begin
      bit old_p = pause;
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      if ($urandom_range(0, 24) == 0) step = ~step;
      ft = ($urandom_range(0, 2) == 0);
      if (pause && !old_p) ft = 0;
      if ($urandom_range(0, 79) == 0) bwd = ~bwd;
      if ($urandom_range(0, 79) == 0) vm = ~vm;
      if ($urandom_range(0, 49) == 0) mir = ~mir;
      h = $urandom_range(100, 720);
      v = $urandom_range(100, 400);
      cycle();
      if (i == 1500) begin
        async_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
      end
    end

    ft = 0;
    repeat (3) cycle();
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
